// File: rtl/lfsr_prng_gen.sv
// Galois-LFSR pseudo-random word generator with seed load and req/valid/busy handshake.
// Optional zero-seed lockup guard enabled by defining LFSR_LOCKUP_GUARD_EN.
module lfsr_prng_gen #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
    parameter int               OUT_BITS     = 8,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'h0001
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [WIDTH-1:0]    seed_in,
    input  logic                seed_load,
    input  logic                req,
    output logic [OUT_BITS-1:0] rnd_out,
    output logic                rnd_valid,
    output logic                busy,
    output logic [WIDTH-1:0]    lfsr_q,
    output logic                lock_err
);

    localparam int CW = $clog2(OUT_BITS + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(OUT_BITS - 1);

    typedef enum logic {IDLE, GEN} state_t;

    state_t                state, state_nxt;
    logic [WIDTH-1:0]      lfsr_nxt;
    logic [OUT_BITS-2:0]   shreg, shreg_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [OUT_BITS-1:0]   rnd_out_nxt;
    logic                  rnd_valid_nxt;
    logic                  busy_nxt;
    logic                  lock_err_nxt;

    logic [WIDTH-1:0]      step_in;
    logic                  fb;
    logic [WIDTH-1:0]      stepped;
    logic [OUT_BITS-1:0]   shifted;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            lfsr_q    <= DEFAULT_SEED;
            shreg     <= '0;
            cnt       <= '0;
            rnd_out   <= '0;
            rnd_valid <= 1'b0;
            busy      <= 1'b0;
            lock_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            lfsr_q    <= lfsr_nxt;
            shreg     <= shreg_nxt;
            cnt       <= cnt_nxt;
            rnd_out   <= rnd_out_nxt;
            rnd_valid <= rnd_valid_nxt;
            busy      <= busy_nxt;
            lock_err  <= lock_err_nxt;
        end
    end

    always_comb begin
        step_in = lfsr_q;
`ifdef LFSR_LOCKUP_GUARD_EN
        // A stuck-at-zero register is restarted from the default seed.
        if (lfsr_q == '0)
            step_in = DEFAULT_SEED;
`endif
        fb      = step_in[0];
        stepped = fb ? ((step_in >> 1) ^ TAPS) : (step_in >> 1);
        shifted = {shreg, fb};
    end

    always_comb begin
        state_nxt     = state;
        lfsr_nxt      = lfsr_q;
        shreg_nxt     = shreg;
        cnt_nxt       = cnt;
        rnd_out_nxt   = rnd_out;
        rnd_valid_nxt = 1'b0;
        busy_nxt      = 1'b0;
        lock_err_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (seed_load) begin
                    lfsr_nxt = seed_in;
`ifdef LFSR_LOCKUP_GUARD_EN
                    if (seed_in == '0) begin
                        lfsr_nxt     = DEFAULT_SEED;
                        lock_err_nxt = 1'b1;
                    end
`endif
                end
                if (req) begin
                    state_nxt = GEN;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            GEN: begin
                lfsr_nxt  = stepped;
                shreg_nxt = shifted[OUT_BITS-2:0];
                cnt_nxt   = cnt + CW'(1);
                if (cnt == LAST_STEP) begin
                    rnd_out_nxt   = shifted;
                    rnd_valid_nxt = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    busy_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lfsr_prng_gen.sv
// Directed, table-driven bench for lfsr_prng_gen with hand-computed LFSR words.
module tb_lfsr_prng_gen;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [15:0] seed_in;
    logic        seed_load;
    logic        req;
    logic [7:0]  rnd_out;
    logic        rnd_valid;
    logic        busy;
    logic [15:0] lfsr_q;
    logic        lock_err;

    int n_vec = 0;
    int n_err = 0;

    lfsr_prng_gen dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .seed_in   (seed_in),
        .seed_load (seed_load),
        .req       (req),
        .rnd_out   (rnd_out),
        .rnd_valid (rnd_valid),
        .busy      (busy),
        .lfsr_q    (lfsr_q),
        .lock_err  (lock_err)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic        load;
        logic [15:0] seed;
        logic        disturb;
        logic [7:0]  exp_word;
        logic [15:0] exp_lfsr;
        logic        exp_lock;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic win_ok;
        logic [7:0] word;
        seed_load = v.load;
        seed_in   = v.seed;
        req       = 1'b1;
        tick();
        seed_load = 1'b0;
        req       = 1'b0;
        chk($sformatf("v%0d lock_err", idx), 32'(lock_err), 32'(v.exp_lock));
        win_ok = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (busy !== 1'b1 || rnd_valid !== 1'b0)
                win_ok = 1'b0;
            if (v.disturb && i == 3) begin
                seed_load = 1'b1;
                seed_in   = 16'h1234;
                req       = 1'b1;
            end
            tick();
            seed_load = 1'b0;
            req       = 1'b0;
        end
        chk($sformatf("v%0d busy_window", idx), 32'(win_ok), 32'd1);
        chk($sformatf("v%0d valid_pulse", idx), {30'd0, rnd_valid, busy}, 32'b10);
        chk($sformatf("v%0d rnd_out", idx), 32'(rnd_out), 32'(v.exp_word));
        chk($sformatf("v%0d lfsr_q", idx), 32'(lfsr_q), 32'(v.exp_lfsr));
        word = rnd_out;
        tick();
        chk($sformatf("v%0d after_valid", idx), {22'd0, rnd_valid, busy, rnd_out}, {24'd0, word});
    endtask

    initial begin
        int n1, n2;
        logic [7:0] w1, w2;
        logic no_valid;

        vecs[0] = '{1'b0, 16'h0000, 1'b0, 8'h80, 16'h0168, 1'b0};
        vecs[1] = '{1'b0, 16'h0000, 1'b0, 8'h16, 16'h7C41, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, 8'h82, 16'h5B14, 1'b0};
        vecs[3] = '{1'b1, 16'h0001, 1'b0, 8'h80, 16'h0168, 1'b0};
        vecs[4] = '{1'b1, 16'hB400, 1'b0, 8'h00, 16'h00B4, 1'b0};
        vecs[5] = '{1'b1, 16'h002D, 1'b0, 8'hB4, 16'h2288, 1'b0};
        vecs[6] = '{1'b1, 16'h0001, 1'b1, 8'h80, 16'h0168, 1'b0};
`ifdef LFSR_LOCKUP_GUARD_EN
        vecs[7] = '{1'b1, 16'h0000, 1'b0, 8'h80, 16'h0168, 1'b1};
`else
        vecs[7] = '{1'b1, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0};
`endif

        wb_rst_i  = 1'b1;
        seed_in   = '0;
        seed_load = 1'b0;
        req       = 1'b0;
        tick();
        tick();
        wb_rst_i = 1'b0;
        chk("reset lfsr_q", 32'(lfsr_q), 32'h0001);
        chk("reset rnd_out", 32'(rnd_out), 32'h0);
        chk("reset flags", {29'd0, rnd_valid, busy, lock_err}, 32'h0);

        for (int i = 0; i < 7; i++)
            run_vec(i, vecs[i]);

        // Reset in the middle of a word: abort, no valid, defaults restored.
        seed_load = 1'b1;
        seed_in   = 16'h002D;
        req       = 1'b1;
        tick();
        seed_load = 1'b0;
        req       = 1'b0;
        tick();
        tick();
        tick();
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        chk("midrst state", {6'd0, rnd_valid, busy, rnd_out, lfsr_q}, {16'd0, 16'h0001});
        no_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (rnd_valid !== 1'b0 || busy !== 1'b0)
                no_valid = 1'b0;
            tick();
        end
        chk("midrst quiet", 32'(no_valid), 32'd1);

        // Held req: back-to-back words every 9 cycles.
        req = 1'b1;
        n1 = 0;
        do begin
            tick();
            n1++;
        end while (rnd_valid !== 1'b1 && n1 < 30);
        w1 = rnd_out;
        n2 = 0;
        do begin
            tick();
            n2++;
        end while (rnd_valid !== 1'b1 && n2 < 30);
        w2 = rnd_out;
        req = 1'b0;
        chk("b2b first latency", 32'(n1), 32'd9);
        chk("b2b first word", 32'(w1), 32'h80);
        chk("b2b interval", 32'(n2), 32'd9);
        chk("b2b second word", 32'(w2), 32'h16);
        n1 = 0;
        while (busy === 1'b1 && n1 < 20) begin
            tick();
            n1++;
        end
        tick();
        chk("b2b drained", 32'(busy), 32'd0);

        run_vec(7, vecs[7]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
